// File: rtl/irq_aggregator.sv
// irq_aggregator: latches, masks and prioritises up to 16 interrupt lines into one registered irq_out.
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer on irq_in for cross-clock sources.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000,
    parameter logic [15:0] RESET_EDGE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq_out
);
    typedef logic [NUM_IRQ-1:0] vec_t;

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_ACTIVE  = 3'd2;
    localparam logic [2:0] A_HIGHEST = 3'd3;
    localparam logic [2:0] A_EDGE    = 3'd4;
    localparam logic [2:0] A_OVERRUN = 3'd5;

    vec_t irq_s;

`ifdef IRQ_SYNC_EN
    // Edge detection stays disarmed until the synchronizer has refilled after reset.
    localparam int ARM_W = 3;
    vec_t sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    localparam int ARM_W = 1;
    assign irq_s = irq_in;
`endif

    logic             wr_en;
    vec_t             wdata;
    vec_t             set_s, clr_pend, clr_ovr, active;
    vec_t             pending_q, pending_d;
    vec_t             overrun_q, overrun_d;
    vec_t             mask_q, mask_d;
    vec_t             edge_q, edge_d;
    vec_t             prev_q;
    logic [ARM_W-1:0] arm_q;
    logic [15:0]      readdata_q, readdata_d;
    logic             irq_out_q;
    logic [3:0]       highest;
    logic             valid;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[NUM_IRQ-1:0];
    assign unused_wd = &{1'b0, writedata};
    assign active    = pending_q & mask_q;

    // The first sample after reset only primes prev_q, so a line already high is not an edge.
    assign set_s = (edge_q & irq_s & ~prev_q & {NUM_IRQ{arm_q[ARM_W-1]}})
                 | (~edge_q & irq_s);

    always_comb begin
        valid   = 1'b0;
        highest = 4'd0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (active[i] && !valid) begin
                valid   = 1'b1;
                highest = 4'(i);
            end
        end
    end

    always_comb begin
        clr_pend = '0;
        clr_ovr  = '0;
        mask_d   = mask_q;
        edge_d   = edge_q;
        if (wr_en) begin
            case (address)
                A_PENDING: clr_pend = wdata;
                A_MASK:    mask_d   = wdata;
                A_EDGE: begin
                    edge_d   = wdata;
                    clr_pend = wdata ^ edge_q;
                end
                A_OVERRUN: clr_ovr  = wdata;
                default: ;
            endcase
        end
        // A new set always wins over a clear arriving in the same cycle.
        pending_d = set_s | (pending_q & ~clr_pend);
        overrun_d = (set_s & edge_q & pending_q & ~clr_pend) | (overrun_q & ~clr_ovr);
    end

    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            A_PENDING: readdata_d = 16'(pending_q);
            A_MASK:    readdata_d = 16'(mask_q);
            A_ACTIVE:  readdata_d = 16'(active);
            A_HIGHEST: readdata_d = {valid, 11'b0, highest};
            A_EDGE:    readdata_d = 16'(edge_q);
            A_OVERRUN: readdata_d = 16'(overrun_q);
            default:   readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            overrun_q  <= '0;
            mask_q     <= RESET_MASK[NUM_IRQ-1:0];
            edge_q     <= RESET_EDGE[NUM_IRQ-1:0];
            prev_q     <= '0;
            arm_q      <= '0;
            readdata_q <= 16'h0000;
            irq_out_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            prev_q     <= irq_s;
            arm_q      <= (arm_q << 1) | ARM_W'(1);
            readdata_q <= readdata_d;
            irq_out_q  <= |active;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule
